// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, 2-FF row synchronizer, press/release debounce, keystrobe/keycode.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_RATE     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       keystrobe,
  output logic [3:0] keycode,
  output logic       keyvalid
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned REP_W = $clog2(REPEAT_DELAY);

  if (SCAN_DIV < 3 || DEBOUNCE_CYCLES < 2 || REPEAT_RATE < 2 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, STROBE, HELD} state_t;

  state_t           state_q, state_d;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       rs_q, rs_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  logic [DIV_W-1:0] dwell_q, dwell_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [DEB_W-1:0] rel_q, rel_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic             keystrobe_q, keystrobe_d;
  logic [3:0]       keycode_q, keycode_d;
  logic             keyvalid_q, keyvalid_d;
`ifdef KEYPAD_REPEAT_EN
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  logic       row_low;
  logic [1:0] first_low;
  logic [1:0] col_adv;

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    sync1_d     = row;
    rs_d        = sync1_q;
    col_idx_d   = col_idx_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    rel_d       = rel_q;
    row_idx_d   = row_idx_q;
    keystrobe_d = 1'b0;
    keycode_d   = keycode_q;
    keyvalid_d  = keyvalid_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
`endif
    row_low = ~rs_q[row_idx_q];
    col_adv = col_idx_q + 2'd1;

    // Lowest-index active row wins when several rows of one column are low
    if (!rs_q[0])      first_low = 2'd0;
    else if (!rs_q[1]) first_low = 2'd1;
    else if (!rs_q[2]) first_low = 2'd2;
    else               first_low = 2'd3;

    case (state_q)
      SCAN: begin
        if (dwell_q == DIV_W'(SCAN_DIV - 1)) begin
          dwell_d = '0;
          if (rs_q != 4'hF) begin
            row_idx_d = first_low;
            deb_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_adv;
          end
        end else begin
          dwell_d = dwell_q + DIV_W'(1);
        end
      end
      DEBOUNCE: begin
        if (row_low) begin
          if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            state_d     = STROBE;
            keystrobe_d = 1'b1;
            keyvalid_d  = 1'b1;
            keycode_d   = {row_idx_q, col_idx_q};
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end else begin
          col_idx_d = col_adv;
          dwell_d   = '0;
          state_d   = SCAN;
        end
      end
      STROBE: begin
        state_d = HELD;
        rel_d   = '0;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = REP_W'(1);
`endif
      end
      HELD: begin
        if (!row_low) begin
          if (rel_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            keyvalid_d = 1'b0;
            col_idx_d  = col_adv;
            dwell_d    = '0;
            state_d    = SCAN;
          end else begin
            rel_d = rel_q + DEB_W'(1);
          end
        end else begin
          rel_d = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        // Repeat counter reloads so the next fire lands REPEAT_RATE cycles later
        if (state_d == HELD) begin
          if (rep_q == REP_W'(REPEAT_DELAY - 1)) begin
            keystrobe_d = 1'b1;
            rep_d       = REP_W'(REPEAT_DELAY - REPEAT_RATE);
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end
`endif
      end
      default: state_d = SCAN;
    endcase

    col_d = ~(4'b0001 << col_idx_d);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      sync1_q     <= 4'hF;
      rs_q        <= 4'hF;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      dwell_q     <= '0;
      deb_q       <= '0;
      rel_q       <= '0;
      row_idx_q   <= 2'd0;
      keystrobe_q <= 1'b0;
      keycode_q   <= 4'd0;
      keyvalid_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      rs_q        <= rs_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      rel_q       <= rel_d;
      row_idx_q   <= row_idx_d;
      keystrobe_q <= keystrobe_d;
      keycode_q   <= keycode_d;
      keyvalid_q  <= keyvalid_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign col       = col_q;
  assign keystrobe = keystrobe_q;
  assign keycode   = keycode_q;
  assign keyvalid  = keyvalid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix; honours KEYPAD_REPEAT_EN.
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        keystrobe;
  logic [3:0]  keycode;
  logic        keyvalid;

  logic [15:0] keys;
  logic [3:0]  force_low;
  int          n_checks;
  int          n_fail;
  int          strobe_cnt;

  keypad_scanner dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .keystrobe (keystrobe),
    .keycode   (keycode),
    .keyvalid  (keyvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    row = row & ~force_low;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (keystrobe) strobe_cnt++;
  endtask

  task automatic wait_col(input string tag, input logic [3:0] target, input int budget);
    int i = 0;
    while (col !== target && i < budget) begin
      tick();
      i++;
    end
    check(tag, 32'(col), 32'(target));
  endtask

  task automatic wait_strobe(input string tag, input int budget);
    int i = 0;
    while (!keystrobe && i < budget) begin
      tick();
      i++;
    end
    check(tag, 32'(keystrobe), 32'd1);
  endtask

  task automatic wait_release(input int budget, output int n);
    n = 0;
    while (keyvalid && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int ticks;
    int c0;
    int cnt;
    int bad;
    int off2;
    int off3;

    n_checks = 0;
    n_fail = 0;
    strobe_cnt = 0;
    keys = '0;
    force_low = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_col", 32'(col), 32'h0E);
    check("rst_strobe", 32'(keystrobe), 32'd0);
    check("rst_code", 32'(keycode), 32'd0);
    check("rst_valid", 32'(keyvalid), 32'd0);
    rst = 1'b0;

    // Row 0 bounces low for 5 cycles at the start of column 3
    wait_col("bounce_find_col3", 4'b0111, 40);
    force_low = 4'b0001;
    n = 1;
    ticks = 0;
    while (col == 4'b0111 && ticks < 40) begin
      tick();
      ticks++;
      if (ticks == 5) force_low = 4'b0000;
      if (col == 4'b0111) n++;
    end
    force_low = 4'b0000;
    check("bounce_col3_cycles", 32'(n), 32'd8);
    check("bounce_next_col", 32'(col), 32'h0E);
    check("bounce_code", 32'(keycode), 32'd0);
    check("bounce_valid", 32'(keyvalid), 32'd0);
    check("bounce_strobes", 32'(strobe_cnt), 32'd0);

    // Clean press of key 9 starting at the first dwell cycle of column 1
    wait_col("k9_find_col1", 4'b1101, 40);
    keys[9] = 1'b1;
    n = 0;
    while (!keystrobe && n < 100) begin
      tick();
      n++;
    end
    check("k9_latency", 32'(n), 32'd12);
    check("k9_code", 32'(keycode), 32'd9);
    check("k9_valid", 32'(keyvalid), 32'd1);
    check("k9_col_frozen", 32'(col), 32'h0D);
    repeat (30) tick();
    check("k9_single_strobe", 32'(strobe_cnt), 32'd1);
    check("k9_valid_held", 32'(keyvalid), 32'd1);
    keys = '0;
    wait_release(60, n);
    check("k9_release_cycles", 32'(n), 32'd10);
    check("k9_resume_col2", 32'(col), 32'h0B);
    check("k9_code_held", 32'(keycode), 32'd9);

    // Reset on the fourth debounce cycle of key 6
    wait_col("k6_find_col3", 4'b0111, 40);
    wait_col("k6_find_col2", 4'b1011, 40);
    keys[6] = 1'b1;
    repeat (7) tick();
    rst = 1'b1;
    keys = '0;
    tick();
    check("k6_rst_col", 32'(col), 32'h0E);
    check("k6_rst_strobe", 32'(keystrobe), 32'd0);
    check("k6_rst_valid", 32'(keyvalid), 32'd0);
    check("k6_rst_code", 32'(keycode), 32'd0);
    rst = 1'b0;
    c0 = strobe_cnt;
    repeat (100) tick();
    check("k6_no_strobe_after_rst", 32'(strobe_cnt - c0), 32'd0);

    // Rows 1 and 3 low together in column 2: lowest row wins
    keys[6] = 1'b1;
    keys[14] = 1'b1;
    c0 = strobe_cnt;
    wait_strobe("k6_14_strobe", 100);
    check("k6_14_code", 32'(keycode), 32'd6);
    repeat (20) tick();
    check("k6_14_single", 32'(strobe_cnt - c0), 32'd1);
    keys = '0;
    wait_release(60, n);
    check("k6_14_release_cycles", 32'(n), 32'd10);

    // Key 15 held for 200 cycles from its first strobe
    keys[15] = 1'b1;
    wait_strobe("k15_strobe", 100);
    check("k15_code", 32'(keycode), 32'd15);
    cnt = 1;
    bad = 0;
    off2 = 0;
    off3 = 0;
    for (int i = 1; i < 200; i++) begin
      tick();
      if (keystrobe) begin
        cnt++;
        if (keycode != 4'd15) bad++;
        if (cnt == 2) off2 = i;
        if (cnt == 3) off3 = i;
      end
    end
`ifdef KEYPAD_REPEAT_EN
    check("k15_repeat_count", 32'(cnt), 32'd10);
    check("k15_first_repeat", 32'(off2), 32'd64);
    check("k15_second_repeat", 32'(off3), 32'd80);
`else
    check("k15_strobe_count", 32'(cnt), 32'd1);
    check("k15_no_repeat", 32'(off2), 32'd0);
`endif
    check("k15_repeat_codes", 32'(bad), 32'd0);
    keys = '0;
    wait_release(60, n);
    check("k15_release_cycles", 32'(n), 32'd10);

    // Key 4 release with a one-cycle re-contact after 6 high cycles
    keys[4] = 1'b1;
    wait_strobe("k4_strobe", 100);
    check("k4_code", 32'(keycode), 32'd4);
    repeat (10) tick();
    keys = '0;
    repeat (6) tick();
    check("k4_glitch_pre_valid", 32'(keyvalid), 32'd1);
    keys[4] = 1'b1;
    tick();
    keys = '0;
    c0 = strobe_cnt;
    wait_release(60, n);
    check("k4_glitch_release_cycles", 32'(n), 32'd10);
    check("k4_glitch_no_strobe", 32'(strobe_cnt - c0), 32'd0);
    check("k4_code_held", 32'(keycode), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
